// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch and load/store share one bus, data has priority and a
// starvation counter guarantees fetch progress. Define MEM_ARB_IBUF_EN for a one-entry fetch buffer.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        m_req_d, m_we_d, if_ack_d, d_ack_d;
  logic [31:0] m_addr_d, m_wdata_d, if_rdata_d, d_rdata_d;
  logic        if_pend, d_pend, ibuf_hit, grant_i, grant_d;
  logic [31:0] hit_data;

  // A port still showing its ack this cycle has already been served.
  assign if_pend = if_req && !if_ack;
  assign d_pend  = d_req && !d_ack;

  assign grant_i = (state_q == StIdle) && if_pend && !ibuf_hit &&
                   (!d_pend || streak_q == StarveLim);
  assign grant_d = (state_q == StIdle) && d_pend && !grant_i;

`ifdef MEM_ARB_IBUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;

  assign ibuf_hit = (state_q == StIdle) && if_pend && buf_valid_q &&
                    (if_addr[31:2] == buf_addr_q);
  assign hit_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (state_q == StBusyI && m_ack) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = m_addr[31:2];
      buf_data_d  = m_rdata;
    end else if (grant_d && d_we && d_addr[31:2] == buf_addr_q) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign ibuf_hit = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    m_req_d    = m_req;
    m_we_d     = m_we;
    m_addr_d   = m_addr;
    m_wdata_d  = m_wdata;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;
    unique case (state_q)
      StIdle: begin
        if (ibuf_hit) begin
          if_ack_d   = 1'b1;
          if_rdata_d = hit_data;
        end
        if (grant_i) begin
          state_d   = StBusyI;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          streak_d  = '0;
        end else if (grant_d) begin
          state_d   = StBusyD;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_we ? d_wdata : '0;
          if (streak_q != StarveLim) streak_d = streak_q + 4'd1;
        end
      end
      StBusyI: begin
        if (m_ack) begin
          state_d    = StIdle;
          m_req_d    = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = m_rdata;
        end
      end
      StBusyD: begin
        if (m_ack) begin
          state_d = StIdle;
          m_req_d = 1'b0;
          d_ack_d = 1'b1;
          if (!m_we) d_rdata_d = m_rdata;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      streak_q <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      m_req    <= m_req_d;
      m_we     <= m_we_d;
      m_addr   <= m_addr_d;
      m_wdata  <= m_wdata_d;
      if_ack   <= if_ack_d;
      d_ack    <= d_ack_d;
      if_rdata <= if_rdata_d;
      d_rdata  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle, plus directed
// scenarios with literal expectations. Honours MEM_ARB_IBUF_EN like the design.
module tb_mem_arbiter;
  localparam int unsigned StarveMax = 4;
`ifdef MEM_ARB_IBUF_EN
  localparam int HitLat = 1;
  localparam int HitGrants = 1;
  localparam int PairFetchLat = 1;
`else
  localparam int HitLat = 2;
  localparam int HitGrants = 2;
  localparam int PairFetchLat = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ack, d_ack, m_req, m_we;

  int          checks = 0;
  int          failures = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  bit          spurious = 1'b0;
  logic        prev_mreq = 1'b0;
  logic [32:0] glog[$];

  mem_arbiter #(.STARVE_MAX(StarveMax)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [32:0] glog_at(input int i);
    if (i < glog.size()) return glog[i];
    return '1;
  endfunction

  // ---------------- reference model ----------------
  typedef enum int {MIdle, MFetch, MData} mphase_e;
  mphase_e     ph = MIdle;
  int unsigned streak = 0;
  logic        e_mreq = 1'b0, e_mwe = 1'b0, e_iack = 1'b0, e_dack = 1'b0;
  logic [31:0] e_maddr = '0, e_mwdata = '0, e_irdata = '0, e_drdata = '0;
  logic        t_ip, t_dp, t_hit, t_gi, t_gd;
  logic [31:0] t_hit_data;

  assign t_ip = if_req && !e_iack;
  assign t_dp = d_req && !e_dack;
`ifdef MEM_ARB_IBUF_EN
  logic        bv = 1'b0;
  logic [29:0] ba = '0;
  logic [31:0] bd = '0;
  assign t_hit = (ph == MIdle) && t_ip && bv && (if_addr[31:2] == ba);
  assign t_hit_data = bd;
`else
  assign t_hit = 1'b0;
  assign t_hit_data = '0;
`endif
  // Fetch takes the slot when it is alone or data has had StarveMax turns in a row.
  assign t_gi = (ph == MIdle) && t_ip && !t_hit && (!t_dp || streak == StarveMax);
  assign t_gd = (ph == MIdle) && t_dp && !t_gi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= MIdle; streak <= 0;
      e_mreq <= 1'b0; e_mwe <= 1'b0; e_iack <= 1'b0; e_dack <= 1'b0;
      e_maddr <= '0; e_mwdata <= '0; e_irdata <= '0; e_drdata <= '0;
`ifdef MEM_ARB_IBUF_EN
      bv <= 1'b0; ba <= '0; bd <= '0;
`endif
    end else begin
      e_iack <= 1'b0;
      e_dack <= 1'b0;
      if (ph == MFetch && m_ack) begin
        ph <= MIdle; e_mreq <= 1'b0; e_iack <= 1'b1; e_irdata <= m_rdata;
`ifdef MEM_ARB_IBUF_EN
        bv <= 1'b1; ba <= e_maddr[31:2]; bd <= m_rdata;
`endif
      end
      if (ph == MData && m_ack) begin
        ph <= MIdle; e_mreq <= 1'b0; e_dack <= 1'b1;
        if (!e_mwe) e_drdata <= m_rdata;
      end
      if (t_hit) begin
        e_iack <= 1'b1; e_irdata <= t_hit_data;
      end
      if (t_gi) begin
        ph <= MFetch; e_mreq <= 1'b1; e_mwe <= 1'b0; e_maddr <= if_addr; e_mwdata <= '0;
        streak <= 0;
      end
      if (t_gd) begin
        ph <= MData; e_mreq <= 1'b1; e_mwe <= d_we; e_maddr <= d_addr;
        e_mwdata <= d_we ? d_wdata : '0;
        streak <= (streak < StarveMax) ? streak + 1 : streak;
`ifdef MEM_ARB_IBUF_EN
        if (d_we && d_addr[31:2] == ba) bv <= 1'b0;
`endif
      end
    end
  end

  // ---------------- per-cycle compare and grant log ----------------
  initial begin
    #3;
    forever begin
      @(negedge clk);
      check("m_req", 64'(m_req), 64'(e_mreq));
      check("m_we", 64'(m_we), 64'(e_mwe));
      check("m_addr", 64'(m_addr), 64'(e_maddr));
      check("m_wdata", 64'(m_wdata), 64'(e_mwdata));
      check("if_ack", 64'(if_ack), 64'(e_iack));
      check("if_rdata", 64'(if_rdata), 64'(e_irdata));
      check("d_ack", 64'(d_ack), 64'(e_dack));
      check("d_rdata", 64'(d_rdata), 64'(e_drdata));
      if (m_req && !prev_mreq) glog.push_back({m_we, m_addr});
      prev_mreq = m_req;
    end
  end

  // ---------------- memory responder ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (m_ack) begin
        m_ack = 1'b0;
      end else if (m_req) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_cnt = 0;
          m_ack   = 1'b1;
          m_rdata = m_we ? 32'hBAD0_BAD0 : mem_val(m_addr);
        end
      end else begin
        mem_cnt = 0;
        if (spurious) begin
          m_ack   = 1'b1;
          m_rdata = 32'h1111_1111;
        end
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] data);
    if_addr = a;
    if_req  = 1'b1;
    lat     = 0;
    do begin
      tick();
      lat++;
    end while (!if_ack && lat < 60);
    check("fetch_done", 64'(if_ack), 64'd1);
    data   = if_rdata;
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] data);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    lat     = 0;
    do begin
      tick();
      lat++;
    end while (!d_ack && lat < 60);
    check("data_done", 64'(d_ack), 64'd1);
    data  = d_rdata;
    d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at %0t: got timeout want finish", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int lat, lat2, base;
    logic [31:0] rd, rd2;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);

    // Single fetch, memory acks in the third busy cycle.
    mem_lat = 3;
    base = glog.size();
    do_fetch(32'h100, lat, rd);
    check("fetch_lat", 64'(lat), 64'd4);
    check("fetch_data", 64'(rd), 64'h0050_0093);
    check("fetch_grant", 64'(glog_at(base)), 64'({1'b0, 32'h100}));
    tick();
    check("fetch_ack_pulse", 64'(if_ack), 64'd0);

    // Collision: data first, fetch granted on the edge after d_ack.
    mem_lat = 1;
    base = glog.size();
    fork
      do_fetch(32'h200, lat, rd);
      do_data(1'b0, 32'h2000, 32'h0, lat2, rd2);
    join
    check("coll_fetch_lat", 64'(lat), 64'd4);
    check("coll_data_lat", 64'(lat2), 64'd2);
    check("coll_fetch_data", 64'(rd), 64'h5A5A_0200);
    check("coll_load_data", 64'(rd2), 64'h5A5A_2000);
    check("coll_first", 64'(glog_at(base)), 64'({1'b0, 32'h2000}));
    check("coll_second", 64'(glog_at(base + 1)), 64'({1'b0, 32'h200}));

    // Four data grants in a row make a contending fetch win.
    tick();
    for (int i = 0; i < 4; i++) do_data(1'b0, 32'h1000 + 32'(4 * i), 32'h0, lat2, rd2);
    tick();
    base = glog.size();
    fork
      do_fetch(32'h400, lat, rd);
      do_data(1'b0, 32'h2004, 32'h0, lat2, rd2);
    join
    check("starve_first", 64'(glog_at(base)), 64'({1'b0, 32'h400}));
    check("starve_second", 64'(glog_at(base + 1)), 64'({1'b0, 32'h2004}));
    check("starve_fetch_lat", 64'(lat), 64'd2);

    // Streak cleared by the fetch grant: data wins again.
    tick();
    base = glog.size();
    fork
      do_fetch(32'h404, lat, rd);
      do_data(1'b0, 32'h2008, 32'h0, lat2, rd2);
    join
    check("streak_clr_first", 64'(glog_at(base)), 64'({1'b0, 32'h2008}));

    // Six data grants saturate the streak; fetch still wins.
    tick();
    for (int i = 0; i < 6; i++) do_data(1'b0, 32'h1100 + 32'(4 * i), 32'h0, lat2, rd2);
    tick();
    base = glog.size();
    fork
      do_fetch(32'h408, lat, rd);
      do_data(1'b0, 32'h200C, 32'h0, lat2, rd2);
    join
    check("sat_first", 64'(glog_at(base)), 64'({1'b0, 32'h408}));

    // Store held across five wait cycles; d_rdata keeps the previous load.
    tick();
    do_data(1'b0, 32'h2000, 32'h0, lat2, rd2);
    tick();
    mem_lat = 6;
    fork
      do_data(1'b1, 32'h40, 32'hDEAD_BEEF, lat2, rd2);
      begin
        repeat (3) tick();
        check("st_we", 64'(m_we), 64'd1);
        check("st_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
        check("st_addr", 64'(m_addr), 64'h40);
      end
    join
    check("st_lat", 64'(lat2), 64'd7);
    check("st_rdata_kept", 64'(d_rdata), 64'h5A5A_2000);

    // m_ack while idle is ignored.
    tick();
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    tick();
    tick();
    check("spur_if_ack", 64'(if_ack), 64'd0);
    check("spur_d_ack", 64'(d_ack), 64'd0);
    check("spur_m_req", 64'(m_req), 64'd0);

    // Reset in the middle of a data transaction.
    mem_lat = 20;
    d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
    tick();
    check("rm_busy", 64'(m_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rm_m_req", 64'(m_req), 64'd0);
    check("rm_m_addr", 64'(m_addr), 64'd0);
    check("rm_d_rdata", 64'(d_rdata), 64'd0);
    d_req = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    mem_lat = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rm_no_ack", 64'(d_ack), 64'd0);
    end

    // Repeat fetch (buffer hit when compiled in), store invalidation, hit beside a data grant.
    base = glog.size();
    do_fetch(32'h100, lat, rd);
    check("ib_first_lat", 64'(lat), 64'd2);
    tick();
    do_fetch(32'h100, lat, rd);
    check("ib_second_lat", 64'(lat), 64'(HitLat));
    check("ib_second_data", 64'(rd), 64'h0050_0093);
    check("ib_grants", 64'(glog.size() - base), 64'(HitGrants));
    tick();
    do_data(1'b1, 32'h100, 32'h1234_5678, lat2, rd2);
    tick();
    base = glog.size();
    do_fetch(32'h100, lat, rd);
    check("ib_inval_lat", 64'(lat), 64'd2);
    check("ib_inval_grant", 64'(glog_at(base)), 64'({1'b0, 32'h100}));
    tick();
    fork
      do_fetch(32'h100, lat, rd);
      do_data(1'b0, 32'h2010, 32'h0, lat2, rd2);
    join
    check("ib_pair_fetch_lat", 64'(lat), 64'(PairFetchLat));
    check("ib_pair_data_lat", 64'(lat2), 64'd2);
    check("ib_pair_load", 64'(rd2), 64'h5A5A_2010);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
